alu_req_arbiter: RTL

Two-port arbiter and sequencer that shares the single 4-bit `ALU` between two independent requesters. It accepts one operation at a time through a valid/ready handshake and grants round-robin when both requesters compete. It drives the ALU operand and select inputs from registers, captures the ALU result and carry, and returns them with the requester ID through a backpressured response port. It sits between the command sources and the `ALU` instance.

---
 rtl/alu_req_arbiter_if.sv | 49 ++++
 rtl/alu_req_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundles the two requester ports, the ALU drive/return path and the response port
// shared between the arbiter (slave) and its environment (master).
interface alu_req_arbiter_if #(
    parameter int W  = 4,
    parameter int SW = 3
);
    logic          req0_valid;
    logic          req0_ready;
    logic [W-1:0]  req0_a;
    logic [W-1:0]  req0_b;
    logic [SW-1:0] req0_sel;
    logic          req1_valid;
    logic          req1_ready;
    logic [W-1:0]  req1_a;
    logic [W-1:0]  req1_b;
    logic [SW-1:0] req1_sel;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [SW-1:0] alu_sel;
    logic [W-1:0]  alu_result;
    logic          alu_carry;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_carry;
    logic          rsp_id;
    logic          rsp_err;
    logic          busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_carry,
        input  rsp_valid, rsp_data, rsp_carry, rsp_id, rsp_err, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_carry,
        output rsp_valid, rsp_data, rsp_carry, rsp_id, rsp_err, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters;
// one operation in flight at a time, IDLE -> EXEC -> RESP.
module alu_req_arbiter #(
    parameter int W  = 4,
    parameter int SW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_req_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [SW-1:0] SEL_FIRST_ILLEGAL = SW'(3'd5);

    function automatic logic sel_is_illegal(input logic [SW-1:0] sel);
        return (sel >= SEL_FIRST_ILLEGAL);
    endfunction

    state_t        state_r;
    logic          last_id_r;
    logic          id_r;
    logic          busy_r;
    logic [W-1:0]  alu_a_r;
    logic [W-1:0]  alu_b_r;
    logic [SW-1:0] alu_sel_r;
    logic          rsp_valid_r;
    logic [W-1:0]  rsp_data_r;
    logic          rsp_carry_r;
    logic          rsp_id_r;
    logic          rsp_err_r;

    logic          grant_valid_s;
    logic          grant_id_s;
    logic [W-1:0]  grant_a_s;
    logic [W-1:0]  grant_b_s;
    logic [SW-1:0] grant_sel_s;

    // Grant decision: only in IDLE and outside reset; on a tie the port other than last_id wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (rst_n && (state_r == IDLE)) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~last_id_r;
            end else if (bus.req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end else if (bus.req0_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end else begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Operand selection from the granted port.
    always_comb begin
        grant_a_s   = bus.req0_a;
        grant_b_s   = bus.req0_b;
        grant_sel_s = bus.req0_sel;
        if (grant_id_s) begin
            grant_a_s   = bus.req1_a;
            grant_b_s   = bus.req1_b;
            grant_sel_s = bus.req1_sel;
        end else begin
            grant_a_s   = bus.req0_a;
            grant_b_s   = bus.req0_b;
            grant_sel_s = bus.req0_sel;
        end
    end

    // Sequencer FSM with all registered outputs; last_id resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_id_r   <= 1'b1;
            id_r        <= 1'b0;
            busy_r      <= 1'b0;
            alu_a_r     <= {W{1'b0}};
            alu_b_r     <= {W{1'b0}};
            alu_sel_r   <= {SW{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {W{1'b0}};
            rsp_carry_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        alu_a_r   <= grant_a_s;
                        alu_b_r   <= grant_b_s;
                        alu_sel_r <= grant_sel_s;
                        id_r      <= grant_id_s;
                        last_id_r <= grant_id_s;
                        busy_r    <= 1'b1;
                        state_r   <= EXEC;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                EXEC: begin
                    // Illegal opcodes never leak whatever the ALU happens to produce.
                    if (sel_is_illegal(alu_sel_r)) begin
                        rsp_data_r  <= {W{1'b0}};
                        rsp_carry_r <= 1'b0;
                        rsp_err_r   <= 1'b1;
                    end else begin
                        rsp_data_r  <= bus.alu_result;
                        rsp_carry_r <= bus.alu_carry;
                        rsp_err_r   <= 1'b0;
                    end
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant_valid_s & ~grant_id_s;
    assign bus.req1_ready = grant_valid_s &  grant_id_s;
    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_sel    = alu_sel_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_carry  = rsp_carry_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.busy       = busy_r;

endmodule
